// File: rtl/motor_pkg.sv
// motor_pkg -- shared definitions for the motor drive blocks.
//   mode_e     : H-bridge operating modes (COAST, FWD, REV, BRAKE, DEAD).
//   PWM_PERIOD : cycles per period of the upstream motor PWM generator.
//   CNT_W      : width of the dead-time and watchdog counters.
//   cmd_mode() : maps the control inputs to the commanded mode.
package motor_pkg;

  typedef enum logic [2:0] {
    COAST = 3'd0,
    FWD   = 3'd1,
    REV   = 3'd2,
    BRAKE = 3'd3,
    DEAD  = 3'd4
  } mode_e;

  localparam int PWM_PERIOD = 35000;
  localparam int CNT_W      = 31;

  // Coast dominates (disabled or faulted), then brake, then direction.
  function automatic mode_e cmd_mode(input logic en, input logic fault,
                                     input logic brake, input logic dir);
    if (!en || fault) return COAST;
    else if (brake)   return BRAKE;
    else if (dir)     return REV;
    else              return FWD;
  endfunction

endpackage

// File: rtl/hbridge_deadtime.sv
// hbridge_deadtime -- saturating down-counter that times the gate-off gap.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears the counter
//   load  : load 'value' into the counter this cycle
//   value : count to load (cycles remaining minus one)
//   done  : counter is at zero
module hbridge_deadtime
  import motor_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stops at zero instead of wrapping, so an idle counter stays done.
  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = value;
    else if (cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/hbridge_drv.sv
// hbridge_drv -- H-bridge gate driver with dead-time sequencing.
//   m_clock   : clock, rising edge
//   p_reset   : synchronous active-low reset
//   pwm_in    : PWM from the motor PWM generator
//   en        : drive enable (0 = coast)
//   dir       : 0 = forward, 1 = reverse
//   brake     : 1 = brake (overrides dir when enabled)
//   ah/al     : leg A high/low gate drives
//   bh/bl     : leg B high/low gate drives
//   dead_busy : high while the bridge is in dead time
//   fault     : sticky PWM watchdog fault
// Optional feature: define HBRIDGE_DRV_WDOG_EN to build the PWM watchdog;
// without it fault is tied low.
module hbridge_drv
  import motor_pkg::*;
#(
  parameter int DEAD_CYCLES = 50,
  parameter int WDOG_CYCLES = 2 * PWM_PERIOD
)
(
  input  logic m_clock,
  input  logic p_reset,
  input  logic pwm_in,
  input  logic en,
  input  logic dir,
  input  logic brake,
  output logic ah,
  output logic al,
  output logic bh,
  output logic bl,
  output logic dead_busy,
  output logic fault
);

  // A zero dead time still gets one gate-off cycle.
  localparam int               DEAD_EFF  = (DEAD_CYCLES < 1) ? 1 : DEAD_CYCLES;
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_EFF - 1);

  mode_e state_q, state_d, cmd;
  logic  dt_load, dt_done;
  logic  fault_s;
  logic  ah_q, al_q, bh_q, bl_q, dead_busy_q;
  logic  ah_d, al_d, bh_d, bl_d, dead_busy_d;

`ifdef HBRIDGE_DRV_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(WDOG_CYCLES);

  logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             fault_q, fault_d;

  // Length of the current pwm_in-high run; trips once it reaches the limit.
  // Only a disabled cycle clears the fault.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (!pwm_in)                 wdog_cnt_d = '0;
    else if (wdog_cnt_q != '1)   wdog_cnt_d = wdog_cnt_q + CNT_W'(1);
    if (!en) fault_d = 1'b0;
    else     fault_d = fault_q | (wdog_cnt_d >= WDOG_LIM);
  end

  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      wdog_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign fault_s = fault_q;
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_CYCLES == 0);
  assign fault_s     = 1'b0;
`endif

  hbridge_deadtime u_deadtime (
    .clk   (m_clock),
    .rst_n (p_reset),
    .load  (dt_load),
    .value (DEAD_LOAD),
    .done  (dt_done)
  );

  always_comb begin
    cmd     = cmd_mode(en, fault_s, brake, dir);
    state_d = state_q;
    dt_load = 1'b0;
    case (state_q)
      COAST: state_d = cmd;
      FWD, REV, BRAKE: begin
        if (cmd == COAST) begin
          state_d = COAST;
        end else if (cmd != state_q) begin
          state_d = DEAD;
          dt_load = 1'b1;
        end
      end
      // Command changes between conducting modes do not reload the counter;
      // whatever is commanded when it expires is entered.
      DEAD: begin
        if (cmd == COAST) state_d = COAST;
        else if (dt_done) state_d = cmd;
      end
      default: state_d = COAST;
    endcase

    // Gates are decoded from the next state so they line up with state_q.
    // No mode drives both switches of a leg.
    ah_d        = (state_d == FWD) & pwm_in;
    al_d        = (state_d == REV) | (state_d == BRAKE);
    bh_d        = (state_d == REV) & pwm_in;
    bl_d        = (state_d == FWD) | (state_d == BRAKE);
    dead_busy_d = (state_d == DEAD);
  end

  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      state_q     <= COAST;
      ah_q        <= 1'b0;
      al_q        <= 1'b0;
      bh_q        <= 1'b0;
      bl_q        <= 1'b0;
      dead_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ah_q        <= ah_d;
      al_q        <= al_d;
      bh_q        <= bh_d;
      bl_q        <= bl_d;
      dead_busy_q <= dead_busy_d;
    end
  end

  assign ah        = ah_q;
  assign al        = al_q;
  assign bh        = bh_q;
  assign bl        = bl_q;
  assign dead_busy = dead_busy_q;
  assign fault     = fault_s;

endmodule
